run_ctrl: RTL

Run sequencer for the processor top level. It owns the data-memory write port while it clears memory and preloads host-supplied constants, then holds the core in reset via START. It releases the core, counts execution cycles until the core raises DONE, and reports completion or timeout. It replaces ad-hoc bench-side memory pokes with a synthesizable, repeatable launch sequence.

---
 rtl/run_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/run_ctrl.sv
// run_ctrl: launch sequencer that clears data memory, accepts host preload
// beats, holds the core in reset for a few cycles, then times its run until
// DONE or until the cycle limit expires.
module run_ctrl #(
  parameter int          ADDR_W   = 8,
  parameter int          DATA_W   = 8,
  parameter int          HOLD_CYC = 2,
  parameter int          CNT_W    = 16,
  parameter int unsigned MAX_CYC  = 16'hFFFF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              GO,
  input  logic              pl_valid,
  input  logic [ADDR_W-1:0] pl_addr,
  input  logic [DATA_W-1:0] pl_data,
  input  logic              pl_last,
  output logic              pl_ready,
  output logic              dm_sel,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              START,
  input  logic              DONE,
  output logic              busy,
  output logic              run_done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cyc_cnt
);

  localparam int                HOLD_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(MAX_CYC);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    PRELOAD,
    HOLD,
    RUN,
    FIN,
    TMO
  } stateType;

  stateType          state;
  stateType          nextState;
  logic [ADDR_W-1:0] clrCnt;
  logic [ADDR_W-1:0] clrCntNext;
  logic [HOLD_W-1:0] holdCnt;
  logic [HOLD_W-1:0] holdCntNext;
  logic [CNT_W-1:0]  cycCntNext;
  logic              clrWe;

  // Next-state and counter update rules for the launch sequence
  always_comb begin
    nextState   = state;
    clrCntNext  = clrCnt;
    holdCntNext = holdCnt;
    cycCntNext  = cyc_cnt;
    case (state)
      IDLE, FIN, TMO: begin
        if (GO) begin
          nextState  = CLEAR;
          clrCntNext = '0;
        end
      end
      CLEAR: begin
        clrCntNext = clrCnt + 1'b1;
        if (clrCnt == '1) begin
          nextState = PRELOAD;
        end
      end
      PRELOAD: begin
        if (pl_valid && pl_last) begin
          nextState   = HOLD;
          holdCntNext = '0;
        end
      end
      HOLD: begin
        cycCntNext  = '0;
        holdCntNext = holdCnt + 1'b1;
        if (holdCnt == HOLD_LAST) begin
          nextState = RUN;
        end
      end
      RUN: begin
        if (DONE) begin
          nextState = FIN;
        end else if (cyc_cnt == CNT_LAST) begin
          cycCntNext = CNT_LIMIT;
          nextState  = TMO;
        end else begin
          cycCntNext = cyc_cnt + 1'b1;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // State, counters and the registered status outputs, all decoded from the next state so they change cleanly on the edge
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      clrCnt   <= '0;
      holdCnt  <= '0;
      cyc_cnt  <= '0;
      clrWe    <= 1'b0;
      START    <= 1'b1;
      dm_sel   <= 1'b0;
      pl_ready <= 1'b0;
      busy     <= 1'b0;
      run_done <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= nextState;
      clrCnt   <= clrCntNext;
      holdCnt  <= holdCntNext;
      cyc_cnt  <= cycCntNext;
      clrWe    <= (nextState == CLEAR);
      START    <= (nextState != RUN);
      dm_sel   <= (nextState == CLEAR) || (nextState == PRELOAD);
      pl_ready <= (nextState == PRELOAD);
      busy     <= (nextState inside {CLEAR, PRELOAD, HOLD, RUN});
      run_done <= (nextState == FIN);
      timeout  <= (nextState == TMO);
    end
  end

  // Write port: preload beats pass straight through, otherwise the clear sweep (address wraps back to 0 once the sweep ends)
  always_comb begin
    dm_we    = clrWe;
    dm_addr  = clrCnt;
    dm_wdata = '0;
    if (pl_ready) begin
      dm_we    = pl_valid;
      dm_addr  = pl_addr;
      dm_wdata = pl_data;
    end
  end

endmodule
